// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the single-port RAM port controller.
//   grant_e       : which request channel won the most recent contended cycle
//   read_latency  : RAM read latency in cycles for a given Pipelined setting
//   clog2         : ceiling log2, used to size counters and pointers
package ram_pkg;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } grant_e;

   // A pipelined RAM macro adds one output register stage.
   function automatic int read_latency(input int pipelined);
      return (pipelined != 0) ? 2 : 1;
   endfunction

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      for (int i = 0; i < 32; i++) begin
         if (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo
// Synchronous first-word-fall-through FIFO holding read responses.
// The head word sits in an output register; words arriving while the head is
// occupied go to a backing array read through a register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write one word (caller guarantees space)
//   pop_ready         consumer accepts the head word when out_valid is high
//   out_valid         head word present
//   out_data          head word, stable until popped
module resp_fifo
   import ram_pkg::*;
#(
   parameter int Depth = 4,
   parameter int Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop_ready,
   output logic             out_valid,
   output logic [Width-1:0] out_data
);

   localparam int PW = (Depth > 1) ? clog2(Depth) : 1;
   localparam int CW = clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    store_cnt_reg;
   logic             out_valid_reg;
   logic [Width-1:0] out_data_reg;

   logic pop;
   logic store_empty;
   logic direct;
   logic to_store;
   logic from_store;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop         = out_valid_reg & pop_ready;
   assign store_empty = (store_cnt_reg == '0);
   // A new word bypasses the array when the head register is (or is about
   // to become) free and nothing older is waiting in the array.
   assign direct      = push & (~out_valid_reg | (pop & store_empty));
   assign to_store    = push & ~direct;
   assign from_store  = pop & ~store_empty;

   always_ff @(posedge clk) begin
      if (to_store) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         store_cnt_reg <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         if (direct || from_store) begin
            out_valid_reg <= 1'b1;
         end else if (pop) begin
            out_valid_reg <= 1'b0;
         end
         if (from_store) begin
            out_data_reg <= mem[rd_ptr_reg];
         end else if (direct) begin
            out_data_reg <= push_data;
         end
         if (to_store) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (from_store) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         store_cnt_reg <= store_cnt_reg + CW'(to_store) - CW'(from_store);
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;

endmodule

// File: rtl/ram_sp_port_ctrl.sv
// ram_sp_port_ctrl
// Initiator-side controller for a single-port RAM macro. Write and read
// request streams are arbitrated onto the one RAM port; read data returns in
// request order on a backpressurable response stream.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wr_valid/wr_ready, wr_addr, wr_data   write request channel
//   rd_valid/rd_ready, rd_addr            read request channel
//   rsp_valid/rsp_ready, rsp_data         read response channel
//   ram_cen (active low), ram_rdwen (1=read), ram_a, ram_d, ram_q   RAM port
//   busy                           reads in flight or responses buffered
module ram_sp_port_ctrl
   import ram_pkg::*;
#(
   parameter int AddrWidth = 12,
   parameter int DataWidth = 8,
   parameter int Pipelined = 0,
   parameter int RespDepth = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [AddrWidth-1:0] wr_addr,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 rd_valid,
   output logic                 rd_ready,
   input  logic [AddrWidth-1:0] rd_addr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DataWidth-1:0] rsp_data,
   output logic                 ram_cen,
   output logic                 ram_rdwen,
   output logic [AddrWidth-1:0] ram_a,
   output logic [DataWidth-1:0] ram_d,
   input  logic [DataWidth-1:0] ram_q,
   output logic                 busy
);

   localparam int Lat = read_latency(Pipelined);
   localparam int CW  = clog2(RespDepth + 1);

   // Low while reset is held and for the first edge after release, so no
   // request is granted until reset has been cleanly released.
   logic           active_reg;
   grant_e         last_gnt_reg;
   logic [CW-1:0]  credits_reg;
   logic [CW-1:0]  credits_next;
   logic [Lat-1:0] pipe_reg;
   logic [Lat-1:0] pipe_next;

   logic rd_elig;
   logic wr_fire;
   logic rd_fire;
   logic contention;
   logic rsp_pop;
   logic resp_push;

   // A read may only issue while a response slot is guaranteed for it.
   assign rd_elig    = active_reg & rd_valid & (credits_reg < CW'(RespDepth));
   assign contention = rd_elig & wr_valid;
   assign wr_fire    = active_reg & wr_valid & (~rd_elig | (last_gnt_reg == GNT_READ));
   assign rd_fire    = rd_elig & (~wr_valid | (last_gnt_reg == GNT_WRITE));

   assign wr_ready = wr_fire;
   assign rd_ready = rd_fire;

   always_comb begin
      ram_cen   = 1'b1;
      ram_rdwen = 1'b1;
      ram_a     = '0;
      ram_d     = '0;
      if (wr_fire) begin
         ram_cen   = 1'b0;
         ram_rdwen = 1'b0;
         ram_a     = wr_addr;
         ram_d     = wr_data;
      end else if (rd_fire) begin
         ram_cen   = 1'b0;
         ram_a     = rd_addr;
      end
   end

   assign rsp_pop = rsp_valid & rsp_ready;

   always_comb begin
      credits_next = credits_reg;
      case ({rd_fire, rsp_pop})
         2'b10:   credits_next = credits_reg + CW'(1);
         2'b01:   credits_next = credits_reg - CW'(1);
         default: credits_next = credits_reg;
      endcase
   end

   // Issued-read marker travels one stage per cycle; when it reaches the last
   // stage, ram_q holds that read's word.
   generate
      for (genvar gi = 0; gi < Lat; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            assign pipe_next[gi] = rd_fire;
         end else begin : g_tail
            assign pipe_next[gi] = pipe_reg[gi-1];
         end
      end
   endgenerate

   assign resp_push = pipe_reg[Lat-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_reg   <= 1'b0;
         last_gnt_reg <= GNT_READ;
         credits_reg  <= '0;
         pipe_reg     <= '0;
      end else begin
         active_reg  <= 1'b1;
         credits_reg <= credits_next;
         pipe_reg    <= pipe_next;
         if (contention) begin
            last_gnt_reg <= rd_fire ? GNT_READ : GNT_WRITE;
         end
      end
   end

   resp_fifo #(
      .Depth (RespDepth),
      .Width (DataWidth)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_push),
      .push_data (ram_q),
      .pop_ready (rsp_ready),
      .out_valid (rsp_valid),
      .out_data  (rsp_data)
   );

   assign busy = (credits_reg != '0);

endmodule

// File: tb/tb_ram_sp_port_ctrl.sv
// tb_ram_sp_port_ctrl
// Two controllers (Pipelined=0 and Pipelined=1), each attached to a simple
// RAM macro model, checked every cycle against a transaction-level model:
// reads return the memory contents as of issue time, L+1 cycles later at the
// earliest, in order, limited by RespDepth outstanding reads.
module tb_ram_sp_port_ctrl;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int RD = 4;

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          wr_valid_s  [2];
   logic [AW-1:0] wr_addr_s   [2];
   logic [DW-1:0] wr_data_s   [2];
   logic          rd_valid_s  [2];
   logic [AW-1:0] rd_addr_s   [2];
   logic          rsp_ready_s [2];
   logic          wr_ready_s  [2];
   logic          rd_ready_s  [2];
   logic          rsp_valid_s [2];
   logic [DW-1:0] rsp_data_s  [2];
   logic          ram_cen_s   [2];
   logic          ram_rdwen_s [2];
   logic [AW-1:0] ram_a_s     [2];
   logic [DW-1:0] ram_d_s     [2];
   logic          busy_s      [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'((a * 37 + 11) ^ (a >> 4));
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_inst
         logic [DW-1:0] mem [4096];
         logic [DW-1:0] q1;
         logic [DW-1:0] q2;
         logic [DW-1:0] ram_q;

         initial begin
            for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
            q1 = '0;
            q2 = '0;
         end

         always @(posedge clk) begin
            if (ram_cen_s[gi] === 1'b0) begin
               if (ram_rdwen_s[gi]) q1 <= mem[ram_a_s[gi]];
               else                 mem[ram_a_s[gi]] <= ram_d_s[gi];
            end
            q2 <= q1;
         end

         assign ram_q = (gi == 0) ? q1 : q2;

         ram_sp_port_ctrl #(
            .AddrWidth (AW),
            .DataWidth (DW),
            .Pipelined (gi),
            .RespDepth (RD)
         ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .wr_valid  (wr_valid_s[gi]),
            .wr_ready  (wr_ready_s[gi]),
            .wr_addr   (wr_addr_s[gi]),
            .wr_data   (wr_data_s[gi]),
            .rd_valid  (rd_valid_s[gi]),
            .rd_ready  (rd_ready_s[gi]),
            .rd_addr   (rd_addr_s[gi]),
            .rsp_valid (rsp_valid_s[gi]),
            .rsp_ready (rsp_ready_s[gi]),
            .rsp_data  (rsp_data_s[gi]),
            .ram_cen   (ram_cen_s[gi]),
            .ram_rdwen (ram_rdwen_s[gi]),
            .ram_a     (ram_a_s[gi]),
            .ram_d     (ram_d_s[gi]),
            .ram_q     (ram_q),
            .busy      (busy_s[gi])
         );
      end
   endgenerate

   // ---------------- reference model ----------------
   int            credits   [2];
   bit            last_read [2];
   bit            active    [2];
   rsp_t          rq        [2][$];
   logic [DW-1:0] refmem    [2][4096];

   task automatic check(input string tag, input int k,
                        input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      int            lat;
      logic          ev;
      logic          rd_elig;
      logic          wr_win;
      logic          rd_win;
      logic          pop;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         lat = k + 1;
         if (rst) begin
            check("rst_rsp_valid", k, 32'(rsp_valid_s[k]), 0);
            check("rst_busy",      k, 32'(busy_s[k]),      0);
            check("rst_wr_ready",  k, 32'(wr_ready_s[k]),  0);
            check("rst_rd_ready",  k, 32'(rd_ready_s[k]),  0);
            check("rst_ram_cen",   k, 32'(ram_cen_s[k]),   1);
            check("rst_ram_rdwen", k, 32'(ram_rdwen_s[k]), 1);
            check("rst_ram_a",     k, 32'(ram_a_s[k]),     0);
            check("rst_ram_d",     k, 32'(ram_d_s[k]),     0);
            credits[k]   = 0;
            last_read[k] = 1'b1;
            active[k]    = 1'b0;
            rq[k].delete();
         end else begin
            ev      = (rq[k].size() > 0) && (rq[k][0].due <= cyc);
            rd_elig = active[k] && rd_valid_s[k] && (credits[k] < RD);
            wr_win  = active[k] && wr_valid_s[k] && (!rd_elig || last_read[k]);
            rd_win  = rd_elig && (!wr_valid_s[k] || !last_read[k]);
            ea = wr_win ? wr_addr_s[k] : (rd_win ? rd_addr_s[k] : '0);
            ed = wr_win ? wr_data_s[k] : '0;
            check("wr_ready",  k, 32'(wr_ready_s[k]),  32'(wr_win));
            check("rd_ready",  k, 32'(rd_ready_s[k]),  32'(rd_win));
            check("ram_cen",   k, 32'(ram_cen_s[k]),   32'(!(wr_win || rd_win)));
            check("ram_rdwen", k, 32'(ram_rdwen_s[k]), 32'(!wr_win));
            check("ram_a",     k, 32'(ram_a_s[k]),     32'(ea));
            check("ram_d",     k, 32'(ram_d_s[k]),     32'(ed));
            check("busy",      k, 32'(busy_s[k]),      32'(credits[k] != 0));
            check("rsp_valid", k, 32'(rsp_valid_s[k]), 32'(ev));
            if (ev) check("rsp_data", k, 32'(rsp_data_s[k]), 32'(rq[k][0].d));
            if (wr_win) refmem[k][wr_addr_s[k]] = wr_data_s[k];
            if (rd_win) rq[k].push_back('{refmem[k][rd_addr_s[k]], cyc + lat + 1});
            if (rd_elig && wr_valid_s[k]) last_read[k] = rd_win;
            pop = ev && rsp_ready_s[k];
            if (pop) void'(rq[k].pop_front());
            credits[k] = credits[k] + int'(rd_win) - int'(pop);
            active[k]  = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < 2; k++) begin
         wr_valid_s[k] = 1'b0;
         rd_valid_s[k] = 1'b0;
      end
   endtask

   task automatic send_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      n = 0;
      wr_valid_s[k] = 1'b1;
      wr_addr_s[k]  = a;
      wr_data_s[k]  = d;
      @(negedge clk);
      while (wr_ready_s[k] !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("wr_accept_timeout", k, 32'(n < 50), 1);
      tick();
      wr_valid_s[k] = 1'b0;
   endtask

   task automatic send_rd(input int k, input logic [AW-1:0] a);
      int n;
      n = 0;
      rd_valid_s[k] = 1'b1;
      rd_addr_s[k]  = a;
      @(negedge clk);
      while (rd_ready_s[k] !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("rd_accept_timeout", k, 32'(n < 50), 1);
      tick();
      rd_valid_s[k] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] got [$];
      int            got_step [$];
      int            issued;

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4096; i++) refmem[k][i] = init_val(i);
         wr_valid_s[k]  = 1'b0;
         wr_addr_s[k]   = '0;
         wr_data_s[k]   = '0;
         rd_valid_s[k]  = 1'b0;
         rd_addr_s[k]   = '0;
         rsp_ready_s[k] = 1'b1;
      end

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      check("reset_busy", 0, 32'(busy_s[0]), 0);
      check("reset_cen",  1, 32'(ram_cen_s[1]), 1);
      rst = 1'b0;
      repeat (2) tick();

      // Write then read back on the unpipelined controller
      send_wr(0, 12'h12A, 8'h5C);
      send_rd(0, 12'h12A);
      @(negedge clk);
      check("rsp_too_early", 0, 32'(rsp_valid_s[0]), 0);
      @(negedge clk);
      check("rsp_at_t_plus_2", 0, 32'(rsp_valid_s[0]), 1);
      check("rsp_data_5c", 0, 32'(rsp_data_s[0]), 32'h5C);
      tick();
      $display("txn: write 0x12A<-0x5C then read 0x12A done");

      // Back-to-back reads on the pipelined controller
      got.delete();
      got_step.delete();
      for (int s = 0; s < 13; s++) begin
         rd_valid_s[1] = (s < 8);
         rd_addr_s[1]  = AW'(s);
         @(negedge clk);
         if (s < 8) check("b2b_rd_ready", 1, 32'(rd_ready_s[1]), 1);
         if (rsp_valid_s[1] === 1'b1) begin
            got.push_back(rsp_data_s[1]);
            got_step.push_back(s);
         end
         tick();
      end
      rd_valid_s[1] = 1'b0;
      check("b2b_count", 1, 32'(got.size()), 8);
      for (int j = 0; j < 8 && j < got.size(); j++) begin
         check("b2b_data", 1, 32'(got[j]), 32'(init_val(j)));
         check("b2b_step", 1, 32'(got_step[j]), 32'(j + 3));
      end
      $display("txn: 8 back-to-back reads, %0d responses", got.size());

      // Credit exhaustion under backpressure
      rsp_ready_s[0] = 1'b0;
      rd_valid_s[0]  = 1'b1;
      issued = 0;
      for (int i = 0; i < 10; i++) begin
         rd_addr_s[0] = AW'(12'h200 + $urandom_range(0, 255));
         @(negedge clk);
         if (rd_ready_s[0] === 1'b1) issued++;
         tick();
      end
      check("credit_issued", 0, 32'(issued), 4);
      @(negedge clk);
      check("credit_rd_ready", 0, 32'(rd_ready_s[0]), 0);
      check("credit_busy", 0, 32'(busy_s[0]), 1);
      tick();
      rsp_ready_s[0] = 1'b1;
      @(negedge clk);
      check("pop_cycle_rd_ready", 0, 32'(rd_ready_s[0]), 0);
      tick();
      @(negedge clk);
      check("resume_rd_ready", 0, 32'(rd_ready_s[0]), 1);
      tick();
      rd_valid_s[0] = 1'b0;
      repeat (12) tick();
      $display("txn: credit exhaustion issued=%0d", issued);

      // Round-robin under contention
      wr_valid_s[0] = 1'b1;
      rd_valid_s[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_addr_s[0] = AW'(12'h300 + $urandom_range(0, 255));
         wr_data_s[0] = DW'($urandom);
         rd_addr_s[0] = AW'(12'h200 + $urandom_range(0, 255));
         @(negedge clk);
         check("rr_wr_ready", 0, 32'(wr_ready_s[0]), 32'(i % 2 == 0));
         check("rr_rd_ready", 0, 32'(rd_ready_s[0]), 32'(i % 2 == 1));
         tick();
      end
      idle_all();
      repeat (6) tick();
      $display("txn: 6 contended cycles");

      // Read, write, read of the same address
      got.delete();
      for (int s = 0; s < 8; s++) begin
         rd_valid_s[0] = (s == 0 || s == 2);
         rd_addr_s[0]  = 12'h040;
         wr_valid_s[0] = (s == 1);
         wr_addr_s[0]  = 12'h040;
         wr_data_s[0]  = 8'hAA;
         @(negedge clk);
         if (rsp_valid_s[0] === 1'b1) got.push_back(rsp_data_s[0]);
         tick();
      end
      idle_all();
      check("raw_count", 0, 32'(got.size()), 2);
      if (got.size() == 2) begin
         check("raw_old", 0, 32'(got[0]), 32'(init_val(12'h040)));
         check("raw_new", 0, 32'(got[1]), 32'hAA);
      end
      $display("txn: read/write/read 0x040, %0d responses", got.size());

      // Randomized traffic on both controllers
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < 2; k++) begin
            wr_valid_s[k]  = ($urandom_range(0, 2) == 0);
            wr_addr_s[k]   = AW'($urandom_range(0, 31));
            wr_data_s[k]   = DW'($urandom);
            rd_valid_s[k]  = ($urandom_range(0, 1) == 0);
            rd_addr_s[k]   = AW'($urandom_range(0, 31));
            rsp_ready_s[k] = ($urandom_range(0, 3) != 0);
         end
         tick();
      end
      idle_all();
      rsp_ready_s[0] = 1'b1;
      rsp_ready_s[1] = 1'b1;
      repeat (12) tick();
      check("drain_busy0", 0, 32'(busy_s[0]), 0);
      check("drain_busy1", 1, 32'(busy_s[1]), 0);
      $display("txn: 300 random cycles on both controllers");

      // Reset with two reads in flight
      rsp_ready_s[0] = 1'b0;
      rd_valid_s[0]  = 1'b1;
      rd_addr_s[0]   = 12'h010;
      tick();
      rd_addr_s[0]   = 12'h011;
      tick();
      rd_valid_s[0]  = 1'b0;
      check("pre_rst_busy", 0, 32'(busy_s[0]), 1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_now_rsp_valid", 0, 32'(rsp_valid_s[0]), 0);
      check("rst_now_busy", 0, 32'(busy_s[0]), 0);
      repeat (2) tick();
      rst = 1'b0;
      rsp_ready_s[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("no_stale_rsp", 0, 32'(rsp_valid_s[0]), 0);
         tick();
      end
      $display("txn: reset with reads in flight");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_sp_port_ctrl.md
# ram_sp_port_ctrl

Initiator-side controller for a single-port generic RAM macro: accepts independent valid/ready write and read request streams, arbitrates them onto the one RAM port (active-low clock enable, read/not-write select), tracks the RAM's 1- or 2-cycle read latency and returns read data on a backpressurable valid/ready response stream. Sits between PE-cluster buffer logic and each scratchpad/global-buffer RAM instance, so upstream blocks never see RAM timing.

## Interface
- AddrWidth, 12, RAM address width
- DataWidth, 8, RAM word width
- Pipelined, 0, must match the attached RAM; read latency L = 1 + Pipelined
- RespDepth, 4, response FIFO depth and read-credit count; ≥1, ≥ L+2 for back-to-back reads under continuous rsp_ready

Ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_valid / wr_ready  in / out  1  write request handshake
- wr_addr  in  AddrWidth ; wr_data  in  DataWidth
- rd_valid / rd_ready  in / out  1  read request handshake
- rd_addr  in  AddrWidth
- rsp_valid / rsp_ready  out / in  1  read response handshake
- rsp_data  out  DataWidth  read word, request order
- ram_cen  out  1  RAM clock enable, active low
- ram_rdwen  out  1  1 = read, 0 = write
- ram_a  out  AddrWidth ; ram_d  out  DataWidth
- ram_q  in  DataWidth  RAM read data
- busy  out  1  reads in flight or responses buffered

## Operation
- At most one RAM operation per cycle; a transfer is valid&ready on a request channel; that cycle drives the RAM combinationally: ram_cen=0, ram_rdwen=0 (write, ram_a=wr_addr, ram_d=wr_data) or 1 (read, ram_a=rd_addr).
- No transfer: ram_cen=1, ram_rdwen=1, ram_a=0, ram_d=0.
- Read eligible only if credit counter < RespDepth. Counter +1 on read issue, −1 on response pop, both same cycle -> unchanged; width clog2(RespDepth+1); never exceeds RespDepth.
- Arbitration: only one eligible -> it wins. Both eligible -> round-robin: grant the channel not granted at last contention; contention bit resets to "read last", so first contention grants write.
- Ready is asserted to the winner only; ready may depend on valid of the other channel, not on own valid changing within a cycle.
- Issued-read shift register of length L; at stage L the cycle's ram_q is pushed into the response FIFO (credits guarantee space; overflow is impossible by construction).
- Responses in issue order; rsp_data stable while rsp_valid & !rsp_ready.
- Ordering: RAM is in-order, so a read issued after a write to the same address returns the new data; no forwarding.
- busy = credit counter ≠ 0.

## Timing
- Reset (async assert, sync release): credits 0, pipe cleared, FIFO empty, contention bit "read last"; rsp_valid=0, busy=0, wr_ready=0, rd_ready=0, ram_cen=1, ram_rdwen=1, ram_a=0, ram_d=0. Reset mid-read discards in-flight data; no response is ever produced for it.
- Read issued in cycle t -> ram_q sampled end of cycle t+L -> rsp_valid earliest t+L+1.
- Write issued in cycle t completes at end of t; no response.
- Throughput: one op/cycle; sustained reads at 1/cycle when RespDepth ≥ L+2 and rsp_ready=1.
- Credits full and rsp_ready=1: pop frees a credit for issue in the following cycle (counter is registered).

## Structure
- Shared package ram_pkg: function computing read latency from Pipelined, clog2 helper for counter width.
- One sub-module: resp_fifo (synchronous FIFO, RespDepth × DataWidth, registered output, async active-high rst).
- Arbiter, credit counter, latency shift register inline.

## Test plan
- Reset then single write 0x12A←0x5C, read 0x12A (Pipelined=0): ram_cen low one cycle each, rsp_data=0x5C with rsp_valid two cycles after read issue.
- Pipelined=1: 8 back-to-back reads of preloaded addresses 0..7, rsp_ready=1, RespDepth=4 -> rd_ready continuously high, responses contiguous in order, first 3 cycles after first issue.
- rsp_ready=0, rd_valid=1 continuously: exactly 4 reads issued then rd_ready=0, busy=1; raise rsp_ready -> reads resume one cycle after first pop, no data lost.
- wr_valid and rd_valid held high together for 6 cycles with credits free -> grants alternate W,R,W,R,W,R.
- Read of address 0x040 issued, then write 0x040←0xAA, read 0x040 -> responses old value then 0xAA.
- Assert rst during a cycle with two reads in flight -> rsp_valid=0, busy=0 immediately; after release no stale response appears.
